// File: rtl/can_seq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : can_seq_pkg
// Description : Shared definitions for the CAN controller register sequencer.
//               Covers command op codes, FSM states, controller register
//               addresses, fixed write values and the trim-frame constants.
// Revision    : 1.0 - initial release
// ============================================================================
package can_seq_pkg;

  typedef enum logic [1:0] {
    OP_INIT      = 2'b00,
    OP_TRANSMIT  = 2'b01,
    OP_TRIM      = 2'b10,
    OP_RESET_BUS = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Longest sequence is an extended frame with four data words: 8 writes.
  localparam int c_step_w = 3;

  localparam logic [4:0] c_addr_prescaler = 5'h0F;
  localparam logic [4:0] c_addr_general   = 5'h0E;
  localparam logic [4:0] c_addr_tra_ctrl  = 5'h0D;
  localparam logic [4:0] c_addr_id_hi     = 5'h0C;
  localparam logic [4:0] c_addr_id_lo     = 5'h0B;
  localparam logic [4:0] c_addr_data0     = 5'h0A;  // data words descend 0x0A..0x07
  localparam logic [4:0] c_addr_clr_a     = 5'h05;  // registers zeroed during init
  localparam logic [4:0] c_addr_clr_b     = 5'h04;
  localparam logic [4:0] c_addr_clr_c     = 5'h11;
  localparam logic [4:0] c_addr_clr_d     = 5'h10;
  localparam logic [4:0] c_addr_bus_ctrl  = 5'h12;

  localparam logic [15:0] c_bus_ctrl_val = 16'h8070;

  localparam logic [10:0] c_trim_id   = 11'h555;
  localparam logic [63:0] c_trim_data = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [3:0]  c_dlc_max   = 4'd8;

  function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
    return (dlc > c_dlc_max) ? c_dlc_max : dlc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/can_seq_step.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : can_seq_step
// Description : Combinational map from (op, step index, captured fields) to
//               the register address / write data of that step, plus a flag
//               marking the final write of the sequence.
// Ports       : op, step          - sequence selector and write index
//               ext               - extended identifier in use for this frame
//               prescaler/general - init values
//               id, dlc, data     - frame fields (dlc already clamped)
//               addr, wdata, last - write for this step, last-write flag
// Revision    : 1.0 - initial release
// ============================================================================
module can_seq_step
  import can_seq_pkg::*;
#(
  parameter logic [15:0] GEN_DATA = 16'h009C
) (
  input  op_t                 op,
  input  logic [c_step_w-1:0] step,
  input  logic                ext,
  input  logic [15:0]         prescaler,
  input  logic [15:0]         general,
  input  logic [28:0]         id,
  input  logic [3:0]          dlc,
  input  logic [63:0]         data,
  output logic [4:0]          addr,
  output logic [15:0]         wdata,
  output logic                last
);

  logic [2:0]  w_n_id;
  logic [2:0]  w_n_words;
  logic [2:0]  w_data_end;
  logic [1:0]  w_word_idx;
  logic [15:0] w_word;

  // Frame layout: id words, then ceil(dlc/2) data words, general, control.
  assign w_n_id     = ext ? 3'd2 : 3'd1;
  assign w_n_words  = 3'(({1'b0, dlc} + 5'd1) >> 1);
  assign w_data_end = w_n_id + w_n_words;
  assign w_word_idx = 2'(step - w_n_id);

  always_comb begin
    w_word = 16'h0;
    case (w_word_idx)
      2'd0:    w_word = data[63:48];
      2'd1:    w_word = data[47:32];
      2'd2:    w_word = data[31:16];
      default: w_word = data[15:0];
    endcase
    // Odd length: the final word carries only its high byte.
    if (dlc[0] && ({1'b0, w_word_idx} == (w_n_words - 3'd1))) begin
      w_word[7:0] = 8'h00;
    end
  end

  always_comb begin
    addr  = 5'h00;
    wdata = 16'h0000;
    last  = 1'b0;
    case (op)
      OP_INIT: begin
        case (step)
          3'd0: begin addr = c_addr_prescaler; wdata = prescaler; end
          3'd1: begin addr = c_addr_general;   wdata = general;   end
          3'd2: addr = c_addr_clr_a;
          3'd3: addr = c_addr_clr_b;
          3'd4: addr = c_addr_clr_c;
          3'd5: addr = c_addr_clr_d;
          3'd6: begin addr = c_addr_bus_ctrl; wdata = c_bus_ctrl_val; last = 1'b1; end
          default: last = 1'b1;
        endcase
      end
      OP_RESET_BUS: begin
        if (step == 3'd0) begin
          addr  = c_addr_general;
          wdata = GEN_DATA;
        end else begin
          addr  = c_addr_bus_ctrl;
          wdata = c_bus_ctrl_val;
          last  = 1'b1;
        end
      end
      default: begin  // transmit and trim share the frame layout
        if (step < w_n_id) begin
          if (step == 3'd0) begin
            addr  = c_addr_id_hi;
            wdata = ext ? id[28:13] : {id[10:0], 5'h00};
          end else begin
            addr  = c_addr_id_lo;
            wdata = {id[12:0], 3'b000};
          end
        end else if (step < w_data_end) begin
          addr  = c_addr_data0 - {3'b000, w_word_idx};
          wdata = w_word;
        end else if (step == w_data_end) begin
          addr  = c_addr_general;
          wdata = GEN_DATA;
        end else begin
          addr  = c_addr_tra_ctrl;
          wdata = {1'b1, 10'b0, ext, dlc};
          last  = 1'b1;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/can_reg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : can_reg_sequencer
// Description : Accepts one command at a time and plays the matching series
//               of register writes into a CAN controller, holding each write
//               until acknowledged and aborting on an acknowledge timeout.
// Ports       : clk, rst (async, active-low)
//               cmd_valid/cmd_ready/cmd_op + command fields (captured on accept)
//               reg_addr/reg_wdata/reg_we/reg_ack - controller write port
//               busy, done (1-cycle), err (with done, on timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module can_reg_sequencer
  import can_seq_pkg::*;
#(
  parameter bit          EXT_ID_EN   = 1'b0,
  parameter int          ACK_TIMEOUT = 255,
  parameter logic [15:0] GEN_DATA    = 16'h009C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] prescaler_init,
  input  logic [15:0] general_init,
  input  logic [28:0] tx_id,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  input  logic        reg_ack,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int c_tmo_w = $clog2(ACK_TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next;
  op_t                 r_op;
  logic [c_step_w-1:0] r_step;
  logic [c_tmo_w-1:0]  r_tmo;
  logic                r_err;
  logic                r_ext;
  logic [15:0]         r_prescaler;
  logic [15:0]         r_general;
  logic [28:0]         r_id;
  logic [3:0]          r_dlc;
  logic [63:0]         r_data;

  logic [4:0]  w_addr;
  logic [15:0] w_wdata;
  logic        w_last;
  logic        w_timeout;

  // Counter value on the last un-acknowledged WRITE cycle allowed.
  assign w_timeout = (r_tmo == c_tmo_w'(ACK_TIMEOUT - 1));

  can_seq_step #(
    .GEN_DATA (GEN_DATA)
  ) u_step (
    .op        (r_op),
    .step      (r_step),
    .ext       (r_ext),
    .prescaler (r_prescaler),
    .general   (r_general),
    .id        (r_id),
    .dlc       (r_dlc),
    .data      (r_data),
    .addr      (w_addr),
    .wdata     (w_wdata),
    .last      (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_INIT;
      r_step      <= '0;
      r_tmo       <= '0;
      r_err       <= 1'b0;
      r_ext       <= 1'b0;
      r_prescaler <= '0;
      r_general   <= '0;
      r_id        <= '0;
      r_dlc       <= '0;
      r_data      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op        <= op_t'(cmd_op);
            r_step      <= '0;
            r_tmo       <= '0;
            r_err       <= 1'b0;
            r_prescaler <= prescaler_init;
            r_general   <= general_init;
            // Trim is a fixed standard-ID frame loaded in place of the inputs.
            if (op_t'(cmd_op) == OP_TRIM) begin
              r_id   <= {18'b0, c_trim_id};
              r_data <= c_trim_data;
              r_dlc  <= c_dlc_max;
              r_ext  <= 1'b0;
            end else begin
              r_id   <= tx_id;
              r_data <= tx_data;
              r_dlc  <= clamp_dlc(tx_dlc);
              r_ext  <= EXT_ID_EN;
            end
          end
        end
        ST_WRITE: begin
          if (reg_ack) begin
            r_tmo <= '0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + c_tmo_w'(1);
          end
        end
        ST_GAP: begin
          if (!w_last) begin
            r_step <= r_step + c_step_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    reg_we    = 1'b0;
    reg_addr  = 5'h00;
    reg_wdata = 16'h0000;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        reg_we    = 1'b1;
        reg_addr  = w_addr;
        reg_wdata = w_wdata;
        if (reg_ack)        w_next = ST_GAP;
        else if (w_timeout) w_next = ST_FIN;
      end
      ST_GAP: begin
        w_next = w_last ? ST_FIN : ST_WRITE;
      end
      ST_FIN: begin
        done   = 1'b1;
        err    = r_err;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_can_reg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_can_reg_sequencer
// Description : Directed self-checking bench. Instance A uses defaults,
//               instance B enables extended identifiers. Writes are captured
//               at acknowledge time and compared against hand-computed lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_can_reg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd_op;
  logic [15:0] prescaler_init, general_init;
  logic [28:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic        cmd_valid_a, cmd_valid_b, reg_ack_a, reg_ack_b;
  logic        cmd_ready_a, cmd_ready_b, reg_we_a, reg_we_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [4:0]  reg_addr_a, reg_addr_b;
  logic [15:0] reg_wdata_a, reg_wdata_b;
  logic        sel;

  logic        obs_ready, obs_we, obs_busy, obs_done, obs_err;
  logic [4:0]  obs_addr;
  logic [15:0] obs_wdata;

  always #5 clk = ~clk;

  can_reg_sequencer u_dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_op(cmd_op), .prescaler_init(prescaler_init), .general_init(general_init),
    .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .reg_addr(reg_addr_a), .reg_wdata(reg_wdata_a), .reg_we(reg_we_a),
    .reg_ack(reg_ack_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  can_reg_sequencer #(.EXT_ID_EN(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op), .prescaler_init(prescaler_init), .general_init(general_init),
    .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .reg_addr(reg_addr_b), .reg_wdata(reg_wdata_b), .reg_we(reg_we_b),
    .reg_ack(reg_ack_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  assign obs_ready = sel ? cmd_ready_b : cmd_ready_a;
  assign obs_we    = sel ? reg_we_b    : reg_we_a;
  assign obs_busy  = sel ? busy_b      : busy_a;
  assign obs_done  = sel ? done_b      : done_a;
  assign obs_err   = sel ? err_b       : err_a;
  assign obs_addr  = sel ? reg_addr_b  : reg_addr_a;
  assign obs_wdata = sel ? reg_wdata_b : reg_wdata_a;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [20:0] cap_q[$];
  logic [20:0] exp_q[$];
  int          max_we, max_gap, unstable, n_done, n_err, n_err_alone;
  logic [4:0]  post;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_valid(input logic v);
    if (sel) cmd_valid_b = v; else cmd_valid_a = v;
  endtask

  task automatic drive_ack(input logic v);
    if (sel) reg_ack_b = v; else reg_ack_a = v;
  endtask

  // Issue one command and service it. ack_delay = 0 never acknowledges.
  // poke pulses cmd_valid mid-sequence; abort_wr >= 0 resets on that write.
  task automatic run_cmd(input logic [1:0] op, input int ack_delay,
                         input bit poke, input int abort_wr);
    int          we_cnt = 0;
    int          low_cnt = 0;
    bit          ack_now = 0;
    bit          done_seen = 0;
    logic [20:0] first_w = '0;
    cap_q.delete();
    max_we = 0; max_gap = 0; unstable = 0;
    n_done = 0; n_err = 0; n_err_alone = 0; post = '1;
    @(negedge clk);
    cmd_op = op;
    drive_valid(1'b1);
    for (int cyc = 0; cyc < 700 && !done_seen; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        // Inputs change after accept; the running sequence must not see it.
        drive_valid(1'b0);
        cmd_op = ~op;
        prescaler_init = 16'hDEAD; general_init = 16'hBEEF;
        tx_id = 29'h0F0F_0F0F; tx_dlc = 4'hF; tx_data = '1;
      end
      if (poke && cyc == 5) drive_valid(1'b1);
      if (poke && cyc == 6) drive_valid(1'b0);
      if (ack_now) begin
        ack_now = 0;
        drive_ack(1'b0);
      end
      if (obs_we) begin
        if (we_cnt == 0) begin
          first_w = {obs_addr, obs_wdata};
          if (cap_q.size() > 0 && low_cnt > max_gap) max_gap = low_cnt;
          low_cnt = 0;
        end else if ({obs_addr, obs_wdata} !== first_w) begin
          unstable++;
        end
        we_cnt++;
        if (we_cnt > max_we) max_we = we_cnt;
        if (abort_wr >= 0 && cap_q.size() == abort_wr) begin
          #2 rst = 1'b0;
          #1 chk("abort outputs", {8'h0, obs_we, obs_addr, obs_wdata, obs_busy, obs_done, obs_err}, 32'h0);
          for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b1;
            if (obs_done) n_done++;
            if (obs_err) n_err++;
          end
          return;
        end
        if (ack_delay > 0 && we_cnt == ack_delay) begin
          cap_q.push_back(first_w);
          ack_now = 1;
          drive_ack(1'b1);
        end
      end else begin
        we_cnt = 0;
        if (cap_q.size() > 0 && !obs_done) low_cnt++;
      end
      if (obs_done) begin
        n_done++;
        done_seen = 1;
        if (obs_err) n_err++;
      end else if (obs_err) begin
        n_err_alone++;
      end
    end
    drive_ack(1'b0);
    @(negedge clk);
    post = {obs_done, obs_err, obs_ready, obs_busy, obs_we};
  endtask

  task automatic check_writes(input string tag);
    chk({tag, " write count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s write %0d", tag, i),
          (i < cap_q.size()) ? cap_q[i] : 21'h1F_FFFF, exp_q[i]);
    end
    exp_q.delete();
  endtask

  task automatic check_end(input string tag, input int exp_err);
    chk({tag, " done pulses"}, n_done, 1);
    chk({tag, " err pulses"}, n_err, exp_err);
    chk({tag, " err without done"}, n_err_alone, 0);
    chk({tag, " write held stable"}, unstable, 0);
    chk({tag, " idle after done"}, post, 5'b00100);  // done,err,ready,busy,we
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0;
    cmd_valid_a = 0; cmd_valid_b = 0; reg_ack_a = 0; reg_ack_b = 0;
    cmd_op = 2'b00; prescaler_init = '0; general_init = '0;
    tx_id = '0; tx_dlc = '0; tx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset state", {obs_ready, obs_busy, obs_done, obs_err, obs_we, obs_addr, obs_wdata},
        {1'b1, 4'b0, 5'h00, 16'h0000});

    // Init sequence, with a cmd_valid pulse while busy that must be dropped.
    prescaler_init = 16'h0033; general_init = 16'h00E3;
    exp_q = '{{5'h0F, 16'h0033}, {5'h0E, 16'h00E3}, {5'h05, 16'h0000}, {5'h04, 16'h0000},
              {5'h11, 16'h0000}, {5'h10, 16'h0000}, {5'h12, 16'h8070}};
    run_cmd(2'b00, 2, 1'b1, -1);
    check_writes("init");
    check_end("init", 0);
    chk("init gap cycles", max_gap, 1);

    // Standard transmit, odd dlc pads the last word.
    tx_id = 29'h123; tx_dlc = 4'd3; tx_data = 64'h1122_3344_5566_7788;
    exp_q = '{{5'h0C, 16'h2460}, {5'h0A, 16'h1122}, {5'h09, 16'h3300},
              {5'h0E, 16'h009C}, {5'h0D, 16'h8003}};
    run_cmd(2'b01, 2, 1'b0, -1);
    check_writes("tx std");
    check_end("tx std", 0);

    // dlc above 8 clamps; upper id bits ignored in standard mode.
    tx_id = 29'h1FFF_F7FF; tx_dlc = 4'd12; tx_data = 64'h0102_0304_0506_0708;
    exp_q = '{{5'h0C, 16'hFFE0}, {5'h0A, 16'h0102}, {5'h09, 16'h0304}, {5'h08, 16'h0506},
              {5'h07, 16'h0708}, {5'h0E, 16'h009C}, {5'h0D, 16'h8008}};
    run_cmd(2'b01, 1, 1'b0, -1);
    check_writes("tx clamp");
    check_end("tx clamp", 0);

    // dlc 0: identifier, general, control only.
    tx_id = 29'h001; tx_dlc = 4'd0; tx_data = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_q = '{{5'h0C, 16'h0020}, {5'h0E, 16'h009C}, {5'h0D, 16'h8000}};
    run_cmd(2'b01, 3, 1'b0, -1);
    check_writes("tx dlc0");
    check_end("tx dlc0", 0);

    // Extended identifier: 0x0C = id[28:13], 0x0B = {id[12:0],3'b0} = 1EF0<<3.
    sel = 1'b1;
    tx_id = 29'h1ABC_DEF0; tx_dlc = 4'd8; tx_data = 64'h0123_4567_89AB_CDEF;
    exp_q = '{{5'h0C, 16'hD5E6}, {5'h0B, 16'hF780}, {5'h0A, 16'h0123}, {5'h09, 16'h4567},
              {5'h08, 16'h89AB}, {5'h07, 16'hCDEF}, {5'h0E, 16'h009C}, {5'h0D, 16'h8018}};
    run_cmd(2'b01, 2, 1'b0, -1);
    check_writes("tx ext");
    check_end("tx ext", 0);

    // Trim is always a standard frame, even on the extended instance.
    exp_q = '{{5'h0C, 16'hAAA0}, {5'h0A, 16'hAAAA}, {5'h09, 16'hAAAA}, {5'h08, 16'hAAAA},
              {5'h07, 16'hAAAA}, {5'h0E, 16'h009C}, {5'h0D, 16'h8008}};
    run_cmd(2'b10, 2, 1'b0, -1);
    check_writes("trim");
    check_end("trim", 0);

    // No acknowledge: write held 255 cycles, then done+err together.
    sel = 1'b0;
    run_cmd(2'b11, 0, 1'b0, -1);
    chk("timeout we cycles", max_we, 255);
    chk("timeout writes done", cap_q.size(), 0);
    check_end("timeout", 1);

    // Reset during the third transmit write, then a clean reset-bus run.
    tx_id = 29'h123; tx_dlc = 4'd3; tx_data = 64'h1122_3344_5566_7788;
    run_cmd(2'b01, 2, 1'b0, 2);
    chk("abort writes before reset", cap_q.size(), 2);
    chk("abort no done", n_done, 0);
    chk("abort no err", n_err, 0);
    chk("abort ready after release", {obs_ready, obs_busy}, 2'b10);
    exp_q = '{{5'h0E, 16'h009C}, {5'h12, 16'h8070}};
    run_cmd(2'b11, 2, 1'b0, -1);
    check_writes("reset bus");
    check_end("reset bus", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
